i2s_dac_tx: RTL and testbench

- Serial audio transmitter for the codec DAC path; the playback counterpart of the ADC capture block.
- Accepts stereo 16-bit sample pairs from an upstream source (SRAM playback reader) through a valid/ready handshake.
- Holds one pair in a single-entry buffer and serialises it MSB-first on dacdat, framed by the codec-driven daclrc and clocked by bclk.
- Counts underruns, i.e. frames that start with no sample available.

---
 rtl/i2s_dac_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S playback transmitter. Buffers one stereo 16-bit pair taken
// over a valid/ready handshake and shifts it MSB-first onto dacdat. Framing
// comes from the codec-driven daclrc. Everything runs on the codec bit clock.
//
// Latency: the left MSB appears on dacdat two bclk edges after a daclrc fall
// reaches the input. The right MSB follows a daclrc rise with the same delay.
// Backpressure: the buffer holds one entry. in_ready = !buf_full. The buffer
// is freed only when a frame starts and takes the pair. in_ready is high again
// the cycle after that, so a held pair transfers on that edge.
//
// Ports:
//   bclk          bit clock from codec; all logic is clocked on its posedge
//   reset         synchronous, active-high
//   daclrc        codec L/R clock; low = left slot, high = right slot
//   play          playback enable; low forces IDLE and a silent dacdat
//   in_data       sample pair; [2*WIDTH-1:WIDTH] = left, [WIDTH-1:0] = right
//   in_valid      in_data valid
//   in_ready      buffer empty, can accept
//   dacdat        registered serial data to codec
//   underrun_cnt  count of frames started with an empty buffer (saturating)
//
// Build option: define I2S_DAC_MONO_EN to send the left word in both slots.
// In that build in_data[WIDTH-1:0] is ignored.

module i2s_dac_tx #(
    parameter int WIDTH  = 16,
    parameter int UCNT_W = 16
) (
    input  logic                 bclk,
    input  logic                 reset,
    input  logic                 daclrc,
    input  logic                 play,
    input  logic [2*WIDTH-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 dacdat,
    output logic [UCNT_W-1:0]    underrun_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEFT,
        GAP_L,
        RIGHT,
        GAP_R
    } state_t;

    state_t              state_q;
    state_t              state_d;

    // The two most recent daclrc samples. Bit 1 is the older sample.
    logic [1:0]          lrc_hist;
    logic                lrc_fall;
    logic                lrc_rise;

    // Single-entry input buffer.
    logic                buf_full;
    logic [WIDTH-1:0]    buf_l;
`ifndef I2S_DAC_MONO_EN
    logic [WIDTH-1:0]    buf_r;
`else
    logic                unused_right;
`endif
    logic                accept;
    logic                consume;

    // Output shifters. shift_l carries the remaining left bits. hold_r keeps
    // the right word until the rise, then shifts it out.
    logic [WIDTH-1:0]    shift_l;
    logic [WIDTH-1:0]    shift_l_d;
    logic [WIDTH-1:0]    hold_r;
    logic [WIDTH-1:0]    hold_r_d;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic                dacdat_d;
    logic [UCNT_W-1:0]   ucnt_d;

    // Words loaded at the start of a frame: buffer contents or silence.
    logic [WIDTH-1:0]    load_l;
    logic [WIDTH-1:0]    load_r;

    // Edge detection uses the history before this cycle's update. That adds
    // one bclk of delay, which gives the fixed two-edge latency.
    assign lrc_fall = (lrc_hist == 2'b10);
    assign lrc_rise = (lrc_hist == 2'b01);

    assign in_ready = !buf_full;
    assign accept   = in_valid && !buf_full;

`ifdef I2S_DAC_MONO_EN
    assign unused_right = ^in_data[WIDTH-1:0];
`endif

    //--------------------------------------------------------------------
    // Next-state and datapath logic
    //--------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        dacdat_d  = dacdat;
        bit_cnt_d = bit_cnt;
        shift_l_d = shift_l;
        hold_r_d  = hold_r;
        ucnt_d    = underrun_cnt;
        consume   = 1'b0;
        load_l    = '0;
        load_r    = '0;

        if (!play) begin
            // The buffer and counter are kept, so playback resumes cleanly
            // on the next fall after play is set again.
            state_d   = IDLE;
            dacdat_d  = 1'b0;
            bit_cnt_d = '0;
        end else if (lrc_fall) begin
            // A fall always starts a new frame, even in the middle of a word.
            if (buf_full) begin
                load_l  = buf_l;
`ifdef I2S_DAC_MONO_EN
                load_r  = buf_l;
`else
                load_r  = buf_r;
`endif
                consume = 1'b1;
            end else begin
                if (underrun_cnt != {UCNT_W{1'b1}}) begin
                    ucnt_d = underrun_cnt + UCNT_W'(1);
                end
            end
            dacdat_d  = load_l[WIDTH-1];
            shift_l_d = load_l << 1;
            hold_r_d  = load_r;
            bit_cnt_d = CNT_W'(1);
            state_d   = LEFT;
        end else if (lrc_rise && (state_q == LEFT || state_q == GAP_L)) begin
            // A rise during LEFT cuts the left word short. A rise in any
            // other state is not part of a frame that began with a fall.
            dacdat_d  = hold_r[WIDTH-1];
            hold_r_d  = hold_r << 1;
            bit_cnt_d = CNT_W'(1);
            state_d   = RIGHT;
        end else begin
            case (state_q)
                LEFT: begin
                    if (bit_cnt == CNT_W'(WIDTH)) begin
                        dacdat_d = 1'b0;
                        state_d  = GAP_L;
                    end else begin
                        dacdat_d  = shift_l[WIDTH-1];
                        shift_l_d = shift_l << 1;
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                RIGHT: begin
                    if (bit_cnt == CNT_W'(WIDTH)) begin
                        dacdat_d = 1'b0;
                        state_d  = GAP_R;
                    end else begin
                        dacdat_d  = hold_r[WIDTH-1];
                        hold_r_d  = hold_r << 1;
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and both gaps output silence.
                    dacdat_d = 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------
    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------
    always_ff @(posedge bclk) begin
        if (reset) begin
            lrc_hist     <= 2'b00;
            dacdat       <= 1'b0;
            bit_cnt      <= '0;
            shift_l      <= '0;
            hold_r       <= '0;
            underrun_cnt <= '0;
        end else begin
            lrc_hist     <= {lrc_hist[0], daclrc};
            dacdat       <= dacdat_d;
            bit_cnt      <= bit_cnt_d;
            shift_l      <= shift_l_d;
            hold_r       <= hold_r_d;
            underrun_cnt <= ucnt_d;
        end
    end

    //--------------------------------------------------------------------
    // Input buffer
    //--------------------------------------------------------------------
    // accept needs an empty buffer and consume needs a full one, so the two
    // cannot happen on the same edge.
    always_ff @(posedge bclk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
`ifndef I2S_DAC_MONO_EN
            buf_r    <= '0;
`endif
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_l    <= in_data[2*WIDTH-1:WIDTH];
`ifndef I2S_DAC_MONO_EN
            buf_r    <= in_data[WIDTH-1:0];
`endif
        end else if (consume) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: testbench for i2s_dac_tx.
// A slot-level model predicts dacdat, in_ready and underrun_cnt every cycle.
// A table of frames and directed sequences check the handshake and framing.
module tb_i2s_dac_tx;

    localparam int W  = 16;
    localparam int UW = 4;
`ifdef I2S_DAC_MONO_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic            bclk = 1'b0;
    logic            reset;
    logic            daclrc;
    logic            play;
    logic [2*W-1:0]  in_data;
    logic            in_valid;
    logic            in_ready;
    logic            dacdat;
    logic [UW-1:0]   underrun_cnt;

    always #5 bclk = ~bclk;

    i2s_dac_tx #(.WIDTH(W), .UCNT_W(UW)) dut (
        .bclk         (bclk),
        .reset        (reset),
        .daclrc       (daclrc),
        .play         (play),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dacdat       (dacdat),
        .underrun_cnt (underrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] offer_q[$];
    logic           cap_q[$];

    // Reference model state.
    // m_slot: 0 = silent, 1 = left slot, 2 = right slot.
    // m_pos is the number of bits of m_word already sent.
    logic           m_old, m_new;
    logic           m_full;
    logic [W-1:0]   m_bl, m_br;
    int             m_slot;
    int             m_pos;
    logic [W-1:0]   m_word, m_rword;
    logic           m_dac;
    int             m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic fall, rise, acc;
        if (reset) begin
            m_old = 0; m_new = 0; m_full = 0; m_bl = '0; m_br = '0;
            m_slot = 0; m_pos = 0; m_word = '0; m_rword = '0; m_dac = 0; m_cnt = 0;
            return;
        end
        fall = m_old && !m_new;
        rise = !m_old && m_new;
        acc  = in_valid && !m_full;
        if (!play) begin
            m_slot = 0;
            m_dac  = 1'b0;
        end else if (fall) begin
            if (m_full) begin
                m_word  = m_bl;
                m_rword = MONO ? m_bl : m_br;
                m_full  = 1'b0;
            end else begin
                m_word  = '0;
                m_rword = '0;
                if (m_cnt < (1 << UW) - 1) m_cnt++;
            end
            m_slot = 1;
            m_dac  = m_word[W-1];
            m_pos  = 1;
        end else if (rise && m_slot == 1) begin
            m_slot = 2;
            m_word = m_rword;
            m_dac  = m_word[W-1];
            m_pos  = 1;
        end else if (m_slot != 0 && m_pos < W) begin
            m_dac = m_word[W-1-m_pos];
            m_pos++;
        end else begin
            m_dac = 1'b0;
        end
        if (acc) begin
            m_full = 1'b1;
            m_bl   = in_data[2*W-1:W];
            m_br   = in_data[W-1:0];
        end
        m_old = m_new;
        m_new = daclrc;
    endtask

    // One bclk cycle. Inputs are driven, the model steps, and the outputs
    // are compared on the following negedge.
    task automatic tick();
        logic took;
        if (offer_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = offer_q[0];
        end else begin
            in_valid = 1'b0;
        end
        took = in_valid && !m_full && !reset;
        model_step();
        @(posedge bclk);
        @(negedge bclk);
        if (took) void'(offer_q.pop_front());
        check("dacdat", 32'(dacdat), 32'(m_dac));
        check("in_ready", 32'(in_ready), 32'(!m_full));
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
        cap_q.push_back(dacdat);
    endtask

    task automatic push_wait(input logic [2*W-1:0] p);
        int n;
        offer_q.push_back(p);
        n = 0;
        while (offer_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        if (offer_q.size() > 0) begin
            errors++;
            $display("FAIL push_timeout: pair %0h still pending after %0d cycles", p, n);
            offer_q.delete();
        end
    endtask

    // Run one frame: lo cycles with daclrc low, then hi cycles high.
    // Left bits are captured from the second cycle onward. Right bits start
    // two cycles after the rise.
    task automatic frame(input int lo, input int hi, output logic [W-1:0] cl, output logic [W-1:0] cr);
        int nl;
        cap_q.delete();
        daclrc = 1'b0;
        repeat (lo) tick();
        daclrc = 1'b1;
        repeat (hi) tick();
        nl = (lo < W) ? lo : W;
        cl = '0;
        for (int i = 0; i < nl; i++) cl = {cl[W-2:0], cap_q[1+i]};
        cr = '0;
        for (int i = 0; i < W; i++) begin
            if (lo + 1 + i < cap_q.size()) cr = {cr[W-2:0], cap_q[lo+1+i]};
            else cr = {cr[W-2:0], 1'b0};
        end
    endtask

    typedef struct {
        logic [2*W-1:0] pair;
        bit             push;
        int             lo;
        int             hi;
        logic [W-1:0]   exp_l;
        logic [W-1:0]   exp_r;
        int             exp_cnt;
    } vec_t;

    vec_t tbl[6];

    // Stops a stuck run from hanging.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cl, cr;
        int nl;

        tbl[0] = '{32'hA5C3_1234, 1'b1, 18, 18, 16'hA5C3, 16'h1234, 0};
        tbl[1] = '{32'h0, 1'b0, 18, 18, 16'h0000, 16'h0000, 1};
        tbl[2] = '{32'h0, 1'b0, 18, 18, 16'h0000, 16'h0000, 2};
        tbl[3] = '{32'h0, 1'b0, 18, 18, 16'h0000, 16'h0000, 3};
        tbl[4] = '{32'hBEEF_CAFE, 1'b1, 8, 18, 16'hBEEF, MONO ? 16'hBEEF : 16'hCAFE, 3};
        tbl[5] = '{32'h7FFF_0001, 1'b1, 18, 18, 16'h7FFF, MONO ? 16'h7FFF : 16'h0001, 3};

        reset = 1'b1; daclrc = 1'b1; play = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        check("reset_dacdat", 32'(dacdat), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_ucnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0;
        play  = 1'b1;
        repeat (2) tick();

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            if (tbl[v].push) push_wait(tbl[v].pair);
            frame(tbl[v].lo, tbl[v].hi, cl, cr);
            nl = (tbl[v].lo < W) ? tbl[v].lo : W;
            check($sformatf("tbl%0d_left", v), 32'(cl), 32'(tbl[v].exp_l >> (W - nl)));
            check($sformatf("tbl%0d_right", v), 32'(cr), 32'(tbl[v].exp_r));
            check($sformatf("tbl%0d_ucnt", v), 32'(underrun_cnt), 32'(tbl[v].exp_cnt));
        end

        // Underrun counter saturation.
        repeat (12) frame(2, 2, cl, cr);
        check("ucnt_reach_max", 32'(underrun_cnt), 32'(2**UW - 1));
        frame(2, 2, cl, cr);
        check("ucnt_saturated", 32'(underrun_cnt), 32'(2**UW - 1));
        repeat (4) tick();

        // Handshake: P1 is taken, and P2 waits for the fall that uses P1.
        offer_q.push_back(32'h1111_2222);
        offer_q.push_back(32'h3333_4444);
        tick();
        check("hs_p1_taken", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("hs_p2_waiting", 32'(offer_q.size()), 32'd1);
        daclrc = 1'b0;
        tick();
        tick();
        check("hs_ready_after_fall", 32'(in_ready), 32'd1);
        tick();
        check("hs_p2_taken", 32'(in_ready), 32'd0);
        repeat (15) tick();
        daclrc = 1'b1;
        repeat (18) tick();
        frame(18, 18, cl, cr);
        check("hs_p2_left", 32'(cl), 32'h3333);
        check("hs_p2_right", 32'(cr), MONO ? 32'h3333 : 32'h4444);

        // play drops in the middle of LEFT. The buffered pair is kept.
        offer_q.push_back(32'h5555_6666);
        offer_q.push_back(32'h9ABC_DEF0);
        tick();
        daclrc = 1'b0;
        repeat (3) tick();
        repeat (3) tick();
        play = 1'b0;
        tick();
        check("play_off_dacdat", 32'(dacdat), 32'd0);
        check("play_off_buf_kept", 32'(in_ready), 32'd0);
        repeat (10) tick();
        daclrc = 1'b1;
        repeat (18) tick();
        play = 1'b1;
        repeat (2) tick();
        frame(18, 18, cl, cr);
        check("play_resume_left", 32'(cl), 32'h9ABC);
        check("play_resume_right", 32'(cr), MONO ? 32'h9ABC : 32'hDEF0);

        // Reset asserted in the middle of RIGHT.
        push_wait(32'h0F0F_F0F0);
        daclrc = 1'b0;
        repeat (18) tick();
        daclrc = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_dacdat", 32'(dacdat), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_ucnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0;
        repeat (14) tick();

        // Random framing, offers, play changes and occasional resets.
        for (int f = 0; f < 150; f++) begin
            int lo, hi;
            lo = $urandom_range(1, 20);
            hi = $urandom_range(1, 20);
            if (offer_q.size() < 3 && $urandom_range(0, 2) != 0) offer_q.push_back($urandom);
            if ($urandom_range(0, 9) == 0) play = ~play;
            daclrc = 1'b0;
            for (int c = 0; c < lo + hi; c++) begin
                if (c == lo) daclrc = 1'b1;
                if ($urandom_range(0, 59) == 0) play = ~play;
                reset = ($urandom_range(0, 399) == 0);
                tick();
                reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
